// File: rtl/dmi_burst_engine.sv
// DMI burst engine: one outstanding DMI request per beat, with read results queued in a response FIFO.
// A command accepted in cycle N issues in N+1. Read issue stalls while the FIFO is full. A sticky dmistat error drops commands until dmireset.
module dmi_burst_engine #(
  parameter int AddrWidth = 7,
  parameter int DataWidth = 32,
  parameter int RespDepth = 4,
  parameter int LenWidth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [DataWidth-1:0] cmd_data_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic                 cmd_incr_i,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [DataWidth-1:0] dmi_req_data_o,
  output logic [1:0]           dmi_req_op_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [DataWidth-1:0] dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_resp_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic [AddrWidth-1:0] rsp_addr_o,
  output logic                 rsp_err_o,
  output logic [1:0]           dmistat_o,
  input  logic                 dmireset_i,
  output logic                 busy_o
);
  localparam int PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int CntW = $clog2(RespDepth + 1);
  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0]           r_op;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_data;
  logic                 r_incr;
  logic [LenWidth-1:0]  r_remaining;
  logic [1:0]           r_dmistat;

  logic [DataWidth-1:0] r_mem_data [RespDepth];
  logic [AddrWidth-1:0] r_mem_addr [RespDepth];
  logic                 r_mem_err  [RespDepth];
  logic [PtrW-1:0]      r_wptr, r_rptr;
  logic [CntW-1:0]      r_count;

  logic                 w_cmd_start, w_issue_ok, w_req_fire, w_resp_fire, w_last;
  logic                 w_resp_err, w_push, w_pop, w_rsp_vld;
  logic [DataWidth-1:0] w_resp_dat;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RespDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_cmd_start = cmd_valid_i && (r_state == StIdle) && (r_dmistat == 2'd0) &&
                       ((cmd_op_i == OpRead) || (cmd_op_i == OpWrite));
  // Only one request is ever outstanding, so a free slot at issue guarantees room at push.
  assign w_issue_ok  = (r_op == OpWrite) || (r_count < CntW'(RespDepth));
  assign w_req_fire  = (r_state == StIssue) && w_issue_ok && dmi_req_ready_i;
  assign w_resp_fire = (r_state == StWait) && dmi_resp_valid_i;
  assign w_last      = (r_remaining == LenWidth'(1));
  assign w_push      = w_resp_fire && (r_op == OpRead);
  assign w_rsp_vld   = (r_count != '0);
  assign w_pop       = w_rsp_vld && rsp_ready_i;

  always_comb begin
    w_resp_err = 1'b1;
    w_resp_dat = DataWidth'(32'hBAADC0DE);
    case (dmi_resp_resp_i)
      2'd0: begin
        w_resp_err = 1'b0;
        w_resp_dat = dmi_resp_data_i;
      end
      2'd2:    w_resp_dat = DataWidth'(32'hDEADBEEF);
      2'd3:    w_resp_dat = DataWidth'(32'hB051B051);
      default: w_resp_dat = DataWidth'(32'hBAADC0DE);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    cmd_ready_o      = 1'b0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    case (r_state)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (w_cmd_start) w_state_nxt = StIssue;
      end
      StIssue: begin
        dmi_req_valid_o = w_issue_ok;
        if (w_req_fire) w_state_nxt = StWait;
      end
      StWait: begin
        dmi_resp_ready_o = 1'b1;
        if (w_resp_fire) w_state_nxt = (w_resp_err || w_last) ? StIdle : StIssue;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op        <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_incr      <= 1'b0;
      r_remaining <= '0;
    end else if (w_cmd_start) begin
      r_op        <= cmd_op_i;
      r_addr      <= cmd_addr_i;
      r_data      <= cmd_data_i;
      r_incr      <= cmd_incr_i;
      r_remaining <= (cmd_len_i == '0) ? LenWidth'(1) : cmd_len_i;
    end else if (w_resp_fire) begin
      r_remaining <= r_remaining - LenWidth'(1);
      if (r_incr) r_addr <= r_addr + AddrWidth'(1);
    end
  end

  // dmireset takes priority over an error landing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || dmireset_i) begin
      r_dmistat <= 2'd0;
    end else if (w_resp_fire && (r_dmistat == 2'd0) &&
                 ((dmi_resp_resp_i == 2'd2) || (dmi_resp_resp_i == 2'd3))) begin
      r_dmistat <= dmi_resp_resp_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_resp_dat;
      r_mem_addr[r_wptr] <= r_addr;
      r_mem_err[r_wptr]  <= w_resp_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  assign dmi_req_addr_o = r_addr;
  assign dmi_req_data_o = r_data;
  assign dmi_req_op_o   = r_op;
  assign rsp_valid_o    = w_rsp_vld;
  assign rsp_data_o     = w_rsp_vld ? r_mem_data[r_rptr] : '0;
  assign rsp_addr_o     = w_rsp_vld ? r_mem_addr[r_rptr] : '0;
  assign rsp_err_o      = w_rsp_vld ? r_mem_err[r_rptr] : 1'b0;
  assign dmistat_o      = r_dmistat;
  assign busy_o         = (r_state != StIdle);
endmodule

// File: tb/tb_dmi_burst_engine.sv
// Directed bench for dmi_burst_engine: cycle vectors for basic bursts, then hand sequences for
// FIFO backpressure, sticky errors, dmireset and mid-burst reset.
module tb_dmi_burst_engine;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o;
  logic [1:0]  cmd_op_i = '0;
  logic [6:0]  cmd_addr_i = '0;
  logic [31:0] cmd_data_i = '0;
  logic [3:0]  cmd_len_i = '0;
  logic        cmd_incr_i = 1'b0;
  logic        dmi_req_valid_o, dmi_req_ready_i = 1'b0;
  logic [6:0]  dmi_req_addr_o;
  logic [31:0] dmi_req_data_o;
  logic [1:0]  dmi_req_op_o;
  logic        dmi_resp_valid_i = 1'b0, dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i = '0;
  logic [1:0]  dmi_resp_resp_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic [6:0]  rsp_addr_o;
  logic        rsp_err_o;
  logic [1:0]  dmistat_o;
  logic        dmireset_i = 1'b0, busy_o;

  always #5 clk = ~clk;

  dmi_burst_engine #(.AddrWidth(7), .DataWidth(32), .RespDepth(4), .LenWidth(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_len_i(cmd_len_i), .cmd_incr_i(cmd_incr_i),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_data_o(dmi_req_data_o), .dmi_req_op_o(dmi_req_op_o),
    .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
    .dmi_resp_data_i(dmi_resp_data_i), .dmi_resp_resp_i(dmi_resp_resp_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_addr_o(rsp_addr_o), .rsp_err_o(rsp_err_o),
    .dmistat_o(dmistat_o), .dmireset_i(dmireset_i), .busy_o(busy_o)
  );

  typedef struct {
    logic cv; logic [1:0] op; logic [6:0] addr; logic [31:0] dat; logic [3:0] len; logic incr;
    logic rq_rdy; logic rs_vld; logic [31:0] rs_dat; logic [1:0] rs_code; logic rsp_rdy;
    logic e_cmd_rdy; logic e_req_vld; logic [6:0] e_req_addr; logic [1:0] e_req_op; logic [31:0] e_req_dat;
    logic e_resp_rdy; logic e_rsp_vld; logic [31:0] e_rsp_dat; logic [6:0] e_rsp_addr; logic e_rsp_err;
    logic [1:0] e_stat; logic e_busy;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;
  int n_issued, n_resp, err_beat;
  logic [1:0] err_code;
  logic reset_on_err;
  logic [6:0] pend_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic quiet_inputs();
    cmd_valid_i = 1'b0; dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
    rsp_ready_i = 1'b0; dmireset_i = 1'b0;
  endtask

  // Reactive DMI target: always ready, answers every Wait cycle; data tags the request address.
  task automatic drive_resp();
    cmd_valid_i = 1'b0; dmireset_i = 1'b0; rsp_ready_i = 1'b0;
    dmi_req_ready_i  = 1'b1;
    dmi_resp_valid_i = dmi_resp_ready_o;
    dmi_resp_resp_i  = (n_resp == err_beat) ? err_code : 2'd0;
    dmi_resp_data_i  = 32'hC0DE0000 | 32'(pend_addr);
    if (dmi_resp_ready_o) begin
      dmireset_i = reset_on_err && (n_resp == err_beat);
      n_resp++;
    end
    if (dmi_req_valid_o) begin
      n_issued++;
      pend_addr = dmi_req_addr_o;
    end
  endtask

  task automatic serve(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      drive_resp();
    end
  endtask

  task automatic send_cmd(input string name, input logic [1:0] op, input logic [6:0] addr,
                          input logic [3:0] len, input logic incr);
    @(negedge clk);
    quiet_inputs();
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = addr; cmd_data_i = 32'h0;
    cmd_len_i = len; cmd_incr_i = incr;
    check({name, ".cmd_rdy"}, 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic pop_check(input string name, input logic [6:0] a, input logic [31:0] d, input logic e);
    @(negedge clk);
    quiet_inputs();
    rsp_ready_i = 1'b1;
    check({name, ".vld"}, 32'(rsp_valid_o), 32'd1);
    check({name, ".addr"}, 32'(rsp_addr_o), 32'(a));
    check({name, ".data"}, rsp_data_o, d);
    check({name, ".err"}, 32'(rsp_err_o), 32'(e));
  endtask

  task automatic pulse_dmireset();
    @(negedge clk);
    quiet_inputs();
    dmireset_i = 1'b1;
    @(negedge clk);
    dmireset_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Single read, then write burst wrapping 0x7E->0x7F->0x00, nop/reserved ops, len 0 read.
    vecs.push_back('{'1,2'd1,7'h10,'0,4'd1,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1,7'h10,2'd1,'0, '0,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'1,32'h12345678,'0,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'1, '1,'0,'0,'0,'0, '0,'1,32'h12345678,7'h10,'0, '0,'0});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0});
    vecs.push_back('{'1,2'd2,7'h7E,32'hA5A5A5A5,4'd3,'1, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'1,7'h7E,2'd2,32'hA5A5A5A5, '0,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1,7'h7E,2'd2,32'hA5A5A5A5, '0,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'1,'0,'0,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1,7'h7F,2'd2,32'hA5A5A5A5, '0,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'1,'0,'0,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1,7'h00,2'd2,32'hA5A5A5A5, '0,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'1,'0,'0,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0});
    vecs.push_back('{'1,2'd0,7'h33,32'h1,4'd5,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0});
    vecs.push_back('{'1,2'd3,7'h34,32'h2,4'd2,'1, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0});
    vecs.push_back('{'1,2'd1,7'h05,'0,4'd0,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1,7'h05,2'd1,'0, '0,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'1,32'hCAFEF00D,'0,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'1});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'1, '1,'0,'0,'0,'0, '0,'1,32'hCAFEF00D,7'h05,'0, '0,'0});
    vecs.push_back('{'0,'0,'0,'0,'0,'0, '0,'0,'0,'0,'0, '1,'0,'0,'0,'0, '0,'0,'0,'0,'0, '0,'0});

    repeat (2) @(negedge clk);
    check("rst.cmd_rdy", 32'(cmd_ready_o), 32'd1);
    check("rst.req_vld", 32'(dmi_req_valid_o), 32'd0);
    check("rst.resp_rdy", 32'(dmi_resp_ready_o), 32'd0);
    check("rst.rsp_vld", 32'(rsp_valid_o), 32'd0);
    check("rst.rsp_data", rsp_data_o, 32'd0);
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.stat", 32'(dmistat_o), 32'd0);
    rst_i = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      cmd_valid_i = vecs[k].cv; cmd_op_i = vecs[k].op; cmd_addr_i = vecs[k].addr;
      cmd_data_i = vecs[k].dat; cmd_len_i = vecs[k].len; cmd_incr_i = vecs[k].incr;
      dmi_req_ready_i = vecs[k].rq_rdy; dmi_resp_valid_i = vecs[k].rs_vld;
      dmi_resp_data_i = vecs[k].rs_dat; dmi_resp_resp_i = vecs[k].rs_code;
      rsp_ready_i = vecs[k].rsp_rdy; dmireset_i = 1'b0;
      check($sformatf("v%0d.cmd_rdy", k), 32'(cmd_ready_o), 32'(vecs[k].e_cmd_rdy));
      check($sformatf("v%0d.req_vld", k), 32'(dmi_req_valid_o), 32'(vecs[k].e_req_vld));
      if (vecs[k].e_req_vld) begin
        check($sformatf("v%0d.req_addr", k), 32'(dmi_req_addr_o), 32'(vecs[k].e_req_addr));
        check($sformatf("v%0d.req_op", k), 32'(dmi_req_op_o), 32'(vecs[k].e_req_op));
        check($sformatf("v%0d.req_dat", k), dmi_req_data_o, vecs[k].e_req_dat);
      end
      check($sformatf("v%0d.resp_rdy", k), 32'(dmi_resp_ready_o), 32'(vecs[k].e_resp_rdy));
      check($sformatf("v%0d.rsp_vld", k), 32'(rsp_valid_o), 32'(vecs[k].e_rsp_vld));
      if (vecs[k].e_rsp_vld) begin
        check($sformatf("v%0d.rsp_dat", k), rsp_data_o, vecs[k].e_rsp_dat);
        check($sformatf("v%0d.rsp_addr", k), 32'(rsp_addr_o), 32'(vecs[k].e_rsp_addr));
        check($sformatf("v%0d.rsp_err", k), 32'(rsp_err_o), 32'(vecs[k].e_rsp_err));
      end
      check($sformatf("v%0d.stat", k), 32'(dmistat_o), 32'(vecs[k].e_stat));
      check($sformatf("v%0d.busy", k), 32'(busy_o), 32'(vecs[k].e_busy));
    end

    // Read len 6 with host not popping: 4 issue, then stall until entries are popped.
    n_issued = 0; n_resp = 0; err_beat = -1; err_code = 2'd0; reset_on_err = 1'b0; pend_addr = '0;
    send_cmd("bp.cmd", 2'd1, 7'h20, 4'd6, 1'b1);
    serve(30);
    check("bp.issued4", 32'(n_issued), 32'd4);
    check("bp.stall_vld", 32'(dmi_req_valid_o), 32'd0);
    check("bp.busy", 32'(busy_o), 32'd1);
    pop_check("bp.pop0", 7'h20, 32'hC0DE0020, 1'b0);
    pop_check("bp.pop1", 7'h21, 32'hC0DE0021, 1'b0);
    serve(30);
    check("bp.issued6", 32'(n_issued), 32'd6);
    check("bp.done", 32'(busy_o), 32'd0);
    for (int i = 2; i < 6; i++)
      pop_check($sformatf("bp.pop%0d", i), 7'(32'h20 + i), 32'hC0DE0020 + 32'(i), 1'b0);
    @(negedge clk);
    quiet_inputs();
    check("bp.empty", 32'(rsp_valid_o), 32'd0);

    // Busy response on beat 2 of 4 cancels the burst and sets sticky status 3.
    n_issued = 0; n_resp = 0; err_beat = 1; err_code = 2'd3;
    send_cmd("bsy.cmd", 2'd1, 7'h40, 4'd4, 1'b1);
    serve(20);
    check("bsy.issued", 32'(n_issued), 32'd2);
    check("bsy.stat", 32'(dmistat_o), 32'd3);
    check("bsy.busy", 32'(busy_o), 32'd0);
    pop_check("bsy.pop0", 7'h40, 32'hC0DE0040, 1'b0);
    pop_check("bsy.pop1", 7'h41, 32'hB051B051, 1'b1);

    // Sticky status drops commands until dmireset.
    n_issued = 0; n_resp = 0; err_beat = -1;
    send_cmd("blk.cmd", 2'd1, 7'h50, 4'd1, 1'b0);
    serve(10);
    check("blk.issued", 32'(n_issued), 32'd0);
    check("blk.busy", 32'(busy_o), 32'd0);
    check("blk.stat", 32'(dmistat_o), 32'd3);
    check("blk.rsp_vld", 32'(rsp_valid_o), 32'd0);
    pulse_dmireset();
    check("blk.cleared", 32'(dmistat_o), 32'd0);
    send_cmd("blk.cmd2", 2'd1, 7'h50, 4'd1, 1'b0);
    serve(10);
    check("blk.issued2", 32'(n_issued), 32'd1);
    pop_check("blk.pop", 7'h50, 32'hC0DE0050, 1'b0);

    // Error response 2 on beat 1 of 2.
    n_issued = 0; n_resp = 0; err_beat = 0; err_code = 2'd2;
    send_cmd("err.cmd", 2'd1, 7'h61, 4'd2, 1'b1);
    serve(10);
    check("err.issued", 32'(n_issued), 32'd1);
    check("err.stat", 32'(dmistat_o), 32'd2);
    pop_check("err.pop", 7'h61, 32'hDEADBEEF, 1'b1);
    pulse_dmireset();
    check("err.cleared", 32'(dmistat_o), 32'd0);

    // dmireset in the same cycle as an error response wins.
    n_issued = 0; n_resp = 0; err_beat = 0; err_code = 2'd2; reset_on_err = 1'b1;
    send_cmd("coin.cmd", 2'd1, 7'h62, 4'd1, 1'b0);
    serve(10);
    reset_on_err = 1'b0;
    check("coin.stat", 32'(dmistat_o), 32'd0);
    pop_check("coin.pop", 7'h62, 32'hDEADBEEF, 1'b1);

    // Undefined response code 1: error beat, status unchanged.
    n_issued = 0; n_resp = 0; err_beat = 0; err_code = 2'd1;
    send_cmd("rc1.cmd", 2'd1, 7'h63, 4'd2, 1'b1);
    serve(10);
    check("rc1.issued", 32'(n_issued), 32'd1);
    check("rc1.stat", 32'(dmistat_o), 32'd0);
    pop_check("rc1.pop", 7'h63, 32'hBAADC0DE, 1'b1);

    // Reset while waiting on beat 3 with two entries queued.
    n_issued = 0; n_resp = 0; err_beat = -1;
    send_cmd("mrst.cmd", 2'd1, 7'h70, 4'd4, 1'b1);
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (n_resp == 2 && dmi_resp_ready_o) got = 1'b1;
        else drive_resp();
      end
      check("mrst.reached_wait", 32'(got), 32'd1);
    end
    quiet_inputs();
    check("mrst.pre_vld", 32'(rsp_valid_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'h11112222; dmi_resp_resp_i = 2'd0;
    check("mrst.busy", 32'(busy_o), 32'd0);
    check("mrst.rsp_vld", 32'(rsp_valid_o), 32'd0);
    check("mrst.resp_rdy", 32'(dmi_resp_ready_o), 32'd0);
    check("mrst.cmd_rdy", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    dmi_resp_valid_i = 1'b0;
    check("mrst.late_rsp_vld", 32'(rsp_valid_o), 32'd0);
    check("mrst.late_req_vld", 32'(dmi_req_valid_o), 32'd0);
    check("mrst.late_busy", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
